// File: rtl/scroll_floor.sv
// Ground renderer with a left-scrolling dash pattern that freezes on collision.
// Optional SCROLL_ACCEL_EN: speed steps up every ACCEL_FRAMES frames, capped at SPEED_MAX.
module scroll_floor #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int GRASS_TOP  = 375,
    parameter int FLOOR_TOP  = 391,
    parameter int DASH_TOP   = 420,
    parameter int DASH_BOT   = 424,
    parameter int TILE_W     = 128,
    parameter int DASH_W     = 64,
    parameter int SPEED_INIT = 2,
    parameter int SPEED_MAX  = 8
`ifdef SCROLL_ACCEL_EN
    ,
    parameter int ACCEL_FRAMES = 600
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       hit,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       grass,
    output logic       floor,
    output logic       dash,
    output logic       running,
    output logic [3:0] speed
);

    localparam int OFF_W = $clog2(TILE_W);

    localparam logic [10:0] H_RES_C     = 11'(H_RES);
    localparam logic [10:0] V_RES_C     = 11'(V_RES);
    localparam logic [10:0] GRASS_TOP_C = 11'(GRASS_TOP);
    localparam logic [10:0] FLOOR_TOP_C = 11'(FLOOR_TOP);
    localparam logic [10:0] DASH_TOP_C  = 11'(DASH_TOP);
    localparam logic [10:0] DASH_BOT_C  = 11'(DASH_BOT);
    localparam logic [OFF_W-1:0] DASH_W_C = OFF_W'(DASH_W);
    // A misconfigured initial speed above the ceiling is clamped rather than trusted.
    localparam logic [3:0] SPEED_INIT_C = 4'((SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT);

`ifdef SCROLL_ACCEL_EN
    localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ACCEL_FRAMES - 1);
    localparam logic [3:0]       SPEED_MAX_C = 4'(SPEED_MAX);
    logic [CNT_W-1:0] frame_cnt_q;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t           state_q;
    logic [OFF_W-1:0] offset_q;
    logic [OFF_W-1:0] offset_adv;
    logic [3:0]       speed_q;
    logic             running_q;
    logic             grass_q, floor_q, dash_q;
    logic             grass_d, floor_d, dash_d;
    logic             in_view;
    logic [10:0]      y_ext;
    logic [OFF_W-1:0] tile_pos;

    assign offset_adv = OFF_W'((OFF_W + 4)'(offset_q) + (OFF_W + 4)'(speed_q));

    // Tile position is taken from the full 11-bit sum, so the wrap is a pure truncation.
    always_comb begin
        in_view  = ({1'b0, x} < H_RES_C) && ({1'b0, y} < V_RES_C);
        y_ext    = {1'b0, y};
        tile_pos = OFF_W'({1'b0, x} + 11'(offset_q));
        dash_d   = in_view && (y_ext >= DASH_TOP_C) && (y_ext <= DASH_BOT_C)
                   && (tile_pos < DASH_W_C);
        grass_d  = in_view && (y_ext >= GRASS_TOP_C) && (y_ext < FLOOR_TOP_C);
        floor_d  = in_view && (y_ext >= FLOOR_TOP_C) && (y_ext < V_RES_C) && !dash_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            offset_q  <= '0;
            speed_q   <= SPEED_INIT_C;
            running_q <= 1'b0;
            grass_q   <= 1'b0;
            floor_q   <= 1'b0;
            dash_q    <= 1'b0;
`ifdef SCROLL_ACCEL_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            grass_q <= grass_d;
            floor_q <= floor_d;
            dash_q  <= dash_d;
            case (state_q)
                IDLE, FROZEN: begin
                    if (start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        offset_q  <= '0;
                        speed_q   <= SPEED_INIT_C;
`ifdef SCROLL_ACCEL_EN
                        frame_cnt_q <= '0;
`endif
                    end
                end
                RUN: begin
                    // A collision on the tick frame wins: the pattern stops where it was.
                    if (hit) begin
                        state_q   <= FROZEN;
                        running_q <= 1'b0;
                    end else if (frame_tick) begin
                        offset_q <= offset_adv;
`ifdef SCROLL_ACCEL_EN
                        if (frame_cnt_q == CNT_LAST) begin
                            frame_cnt_q <= '0;
                            if (speed_q < SPEED_MAX_C) begin
                                speed_q <= speed_q + 4'd1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign grass   = grass_q;
    assign floor   = floor_q;
    assign dash    = dash_q;
    assign running = running_q;
    assign speed   = speed_q;

endmodule

// File: tb/tb_scroll_floor.sv
// Self-checking bench for scroll_floor: classification table, hand sequences and
// randomized traffic against a frame-level model of the scrolling ground.
module tb_scroll_floor;

    localparam int TILE  = 128;
    localparam int DASHL = 64;
    localparam int SINIT = 2;
    localparam int SMAX  = 8;
    localparam int AFR   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       grass, floor, dash, running;
    logic [3:0] speed;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: game phase plus scroll position in plain integers.
    typedef enum int {M_IDLE, M_RUN, M_FROZEN} mphase_t;
    mphase_t mPhase = M_IDLE;
    int mOffset = 0;
    int mSpeed = SINIT;
    int mFrames = 0;

    typedef struct {
        int x;
        int y;
        bit g;
        bit f;
        bit d;
    } classVec_t;

    scroll_floor #(
        .H_RES(640), .V_RES(480), .GRASS_TOP(375), .FLOOR_TOP(391),
        .DASH_TOP(420), .DASH_BOT(424), .TILE_W(TILE), .DASH_W(DASHL),
        .SPEED_INIT(SINIT), .SPEED_MAX(SMAX)
`ifdef SCROLL_ACCEL_EN
        , .ACCEL_FRAMES(AFR)
`endif
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .hit(hit),
        .x(x), .y(y), .grass(grass), .floor(floor), .dash(dash),
        .running(running), .speed(speed)
    );

    always #5 clk = ~clk;

    function automatic void classify(input int px, input int py, input int off,
                                     output bit g, output bit f, output bit d);
        bit valid;
        valid = (px < 640) && (py < 480);
        d = valid && (py >= 420) && (py <= 424) && (((px + off) % TILE) < DASHL);
        g = valid && (py >= 375) && (py < 391);
        f = valid && (py >= 391) && (py < 480) && !d;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock: drive at the falling edge, advance the model, compare after the rising edge.
    task automatic applyStimulus(input bit rst, input bit tk, input bit st, input bit ht,
                                 input int px, input int py);
        bit eg, ef, ed;
        @(negedge clk);
        reset = rst;
        frame_tick = tk;
        start = st;
        hit = ht;
        x = 10'(px);
        y = 10'(py);
        if (rst) begin
            eg = 0; ef = 0; ed = 0;
            mPhase = M_IDLE; mOffset = 0; mSpeed = SINIT; mFrames = 0;
        end else begin
            classify(px, py, mOffset, eg, ef, ed);
            if (st && mPhase != M_RUN) begin
                mPhase = M_RUN; mOffset = 0; mSpeed = SINIT; mFrames = 0;
            end else if (mPhase == M_RUN && ht) begin
                mPhase = M_FROZEN;
            end else if (mPhase == M_RUN && tk) begin
                mOffset = (mOffset + mSpeed) % TILE;
`ifdef SCROLL_ACCEL_EN
                mFrames++;
                if (mFrames == AFR) begin
                    mFrames = 0;
                    if (mSpeed < SMAX) mSpeed++;
                end
`endif
            end
        end
        @(posedge clk);
        #1;
        checkOutput("grass", int'(grass), int'(eg));
        checkOutput("floor", int'(floor), int'(ef));
        checkOutput("dash", int'(dash), int'(ed));
        checkOutput("running", int'(running), (mPhase == M_RUN) ? 1 : 0);
        checkOutput("speed", int'(speed), mSpeed);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        classVec_t vecs[$];
        vecs.push_back('{0, 375, 1, 0, 0});
        vecs.push_back('{639, 390, 1, 0, 0});
        vecs.push_back('{0, 391, 0, 1, 0});
        vecs.push_back('{640, 400, 0, 0, 0});
        vecs.push_back('{0, 374, 0, 0, 0});
        vecs.push_back('{63, 422, 0, 0, 1});
        vecs.push_back('{64, 422, 0, 1, 0});
        vecs.push_back('{128, 422, 0, 0, 1});
        vecs.push_back('{5, 420, 0, 0, 1});
        vecs.push_back('{100, 424, 0, 1, 0});
        vecs.push_back('{10, 425, 0, 1, 0});
        vecs.push_back('{639, 479, 0, 1, 0});
        vecs.push_back('{0, 480, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0});

        applyStimulus(1, 0, 0, 0, 0, 375);
        applyStimulus(1, 0, 0, 0, 0, 375);
        checkOutput("reset_running", int'(running), 0);
        checkOutput("reset_speed", int'(speed), 2);
        checkOutput("reset_grass", int'(grass), 0);

        foreach (vecs[i]) begin
            applyStimulus(0, 0, 0, 0, vecs[i].x, vecs[i].y);
            checkOutput("tbl_grass", int'(grass), int'(vecs[i].g));
            checkOutput("tbl_floor", int'(floor), int'(vecs[i].f));
            checkOutput("tbl_dash", int'(dash), int'(vecs[i].d));
        end

        // Start, three frames at speed 2 -> offset 6.
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("start_running", int'(running), 1);
        ticks(3);
        applyStimulus(0, 0, 0, 0, 58, 422);
        checkOutput("scroll6_x58_dash", int'(dash), 0);
        applyStimulus(0, 0, 0, 0, 57, 422);
        checkOutput("scroll6_x57_dash", int'(dash), 1);
        ticks(61);
`ifndef SCROLL_ACCEL_EN
        applyStimulus(0, 0, 0, 0, 0, 422);
        checkOutput("wrap_x0_dash", int'(dash), 1);
        applyStimulus(0, 0, 0, 0, 64, 422);
        checkOutput("wrap_x64_floor", int'(floor), 1);
`endif

        // Freeze on hit coinciding with a frame tick.
        ticks(5);
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput("freeze_running", int'(running), 0);
        applyStimulus(0, 1, 0, 0, 54, 422);
`ifndef SCROLL_ACCEL_EN
        checkOutput("frozen_x54_dash", int'(dash), 0);
`endif
        applyStimulus(0, 1, 0, 0, 53, 422);
`ifndef SCROLL_ACCEL_EN
        checkOutput("frozen_x53_dash", int'(dash), 1);
`endif
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("restart_running", int'(running), 1);
        applyStimulus(0, 0, 0, 0, 64, 422);
        checkOutput("restart_x64_dash", int'(dash), 0);
        applyStimulus(0, 0, 0, 0, 63, 422);
        checkOutput("restart_x63_dash", int'(dash), 1);

        // Reset in the middle of a run.
        ticks(5);
        applyStimulus(1, 0, 0, 0, 0, 375);
        checkOutput("midreset_grass", int'(grass), 0);
        checkOutput("midreset_speed", int'(speed), 2);
        applyStimulus(0, 1, 0, 0, 64, 422);
        checkOutput("idle_x64_floor", int'(floor), 1);
        applyStimulus(0, 0, 0, 0, 63, 422);
        checkOutput("idle_x63_dash", int'(dash), 1);
        checkOutput("idle_running", int'(running), 0);

`ifdef SCROLL_ACCEL_EN
        applyStimulus(0, 0, 1, 0, 0, 0);
        ticks(4);
        checkOutput("accel_speed3", int'(speed), 3);
        ticks(28);
        checkOutput("accel_speed8", int'(speed), 8);
        ticks(8);
        checkOutput("accel_sat8", int'(speed), 8);
`endif

        for (int i = 0; i < 1500; i++) begin
            int px, py;
            px = int'($urandom_range(0, 1023));
            py = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                             : int'($urandom_range(360, 490));
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 29) == 0,
                          px, py);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
